frame_buffer_reader: RTL and testbench

//   Read side of the camera frame RAM: after a start pulse, sweeps the image RAM byte by byte.

---
 rtl/frame_buffer_reader_pkg.sv | 18 +
 rtl/frame_buffer_reader_ram_read_wait.sv | 37 +++
 rtl/frame_buffer_reader.sv | 161 ++++++++++++++++
 tb/tb_frame_buffer_reader.sv | 313 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/frame_buffer_reader_pkg.sv
// Definitions shared by the frame RAM read path and the camera capture writer:
// reader FSM states and frame geometry.
package frame_buffer_reader_pkg;

    localparam int unsigned FB_ADDR_WIDTH  = 15;
    localparam int unsigned FB_FRAME_BYTES = 19200;
    localparam int unsigned FB_LINE_BYTES  = 160;
    localparam int unsigned FB_RAM_LATENCY = 1;

    typedef enum logic [2:0] {
        IDLE,
        FETCH_HI,
        FETCH_LO,
        PRESENT,
        DONE
    } rd_state_e;

endpackage

// File: rtl/frame_buffer_reader_ram_read_wait.sv
// Down-counter started whenever a new RAM address is issued; data_ready_c is
// high on the edge where the read data for that address is valid.
module frame_buffer_reader_ram_read_wait #(
    parameter int unsigned RAM_LATENCY = 1
) (
    input  logic clk,
    input  logic rst,
    input  logic load,
    output logic data_ready_c
);

    localparam int unsigned CNT_W = $clog2(RAM_LATENCY + 2);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    // Saturates at zero so data stays ready while the address is held.
    always_comb begin
        cnt_d = cnt_q;
        if (load) begin
            cnt_d = CNT_W'(RAM_LATENCY);
        end else if (cnt_q != '0) begin
            cnt_d = cnt_q - CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign data_ready_c = (cnt_q == '0);

endmodule

// File: rtl/frame_buffer_reader.sv
// Read side of the camera frame RAM: sweeps one frame byte by byte and streams
// RGB565 pixels ({high, low}) on a valid/ready interface.
module frame_buffer_reader
    import frame_buffer_reader_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH  = FB_ADDR_WIDTH,
    parameter int unsigned FRAME_BYTES = FB_FRAME_BYTES,
    parameter int unsigned LINE_BYTES  = FB_LINE_BYTES,
    parameter int unsigned RAM_LATENCY = FB_RAM_LATENCY
) (
    input  logic                  i_Clk,
    input  logic                  i_Reset,
    input  logic                  i_Start,
    output logic [ADDR_WIDTH-1:0] o_RAM_Address,
    input  logic [7:0]            i_from_RAM,
    output logic [15:0]           o_Pixel,
    output logic                  o_Pixel_Valid,
    input  logic                  i_Pixel_Ready,
    output logic                  o_Line_End,
    output logic                  o_Busy,
    output logic                  o_Frame_Done
);

    localparam int unsigned BYTE_W = $clog2(FRAME_BYTES);
    localparam int unsigned COL_W  = $clog2(LINE_BYTES);

    rd_state_e         state_q, state_d;
    logic [BYTE_W-1:0] byte_q, byte_d;
    logic [COL_W-1:0]  col_q, col_d;
    logic [15:0]       pixel_q, pixel_d;
    logic              valid_q, valid_d;
    logic              line_end_q, line_end_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;
    logic              last_q, last_d;

    logic              wait_load;
    logic              data_ready_c;
    logic              byte_is_last;
    logic              col_is_last;
    logic [BYTE_W-1:0] byte_inc;
    logic [COL_W-1:0]  col_inc;

    frame_buffer_reader_ram_read_wait #(
        .RAM_LATENCY (RAM_LATENCY)
    ) u_wait (
        .clk          (i_Clk),
        .rst          (i_Reset),
        .load         (wait_load),
        .data_ready_c (data_ready_c)
    );

    // col tracks the byte address modulo LINE_BYTES without a divider.
    assign byte_is_last = (byte_q == BYTE_W'(FRAME_BYTES - 1));
    assign col_is_last  = (col_q == COL_W'(LINE_BYTES - 1));
    assign byte_inc     = byte_q + BYTE_W'(1);
    assign col_inc      = col_is_last ? '0 : col_q + COL_W'(1);

    always_comb begin
        state_d    = state_q;
        byte_d     = byte_q;
        col_d      = col_q;
        pixel_d    = pixel_q;
        valid_d    = valid_q;
        line_end_d = line_end_q;
        busy_d     = busy_q;
        done_d     = 1'b0;
        last_d     = last_q;
        wait_load  = 1'b0;

        case (state_q)
            IDLE: begin
                byte_d = '0;
                col_d  = '0;
                if (i_Start) begin
                    busy_d    = 1'b1;
                    wait_load = 1'b1;
                    state_d   = FETCH_HI;
                end
            end
            FETCH_HI: begin
                if (data_ready_c) begin
                    pixel_d   = {i_from_RAM, pixel_q[7:0]};
                    byte_d    = byte_inc;
                    col_d     = col_inc;
                    wait_load = 1'b1;
                    state_d   = FETCH_LO;
                end
            end
            // The next high-byte read is issued here so it overlaps the PRESENT wait.
            FETCH_LO: begin
                if (data_ready_c) begin
                    pixel_d    = {pixel_q[15:8], i_from_RAM};
                    line_end_d = col_is_last;
                    valid_d    = 1'b1;
                    last_d     = byte_is_last;
                    state_d    = PRESENT;
                    if (!byte_is_last) begin
                        byte_d    = byte_inc;
                        col_d     = col_inc;
                        wait_load = 1'b1;
                    end
                end
            end
            PRESENT: begin
                if (i_Pixel_Ready) begin
                    valid_d    = 1'b0;
                    line_end_d = 1'b0;
                    if (last_q) begin
                        done_d  = 1'b1;
                        state_d = DONE;
                    end else begin
                        state_d = FETCH_HI;
                    end
                end
            end
            DONE: begin
                busy_d  = 1'b0;
                byte_d  = '0;
                col_d   = '0;
                last_d  = 1'b0;
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge i_Clk) begin
        if (i_Reset) begin
            state_q    <= IDLE;
            byte_q     <= '0;
            col_q      <= '0;
            pixel_q    <= '0;
            valid_q    <= 1'b0;
            line_end_q <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            last_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            byte_q     <= byte_d;
            col_q      <= col_d;
            pixel_q    <= pixel_d;
            valid_q    <= valid_d;
            line_end_q <= line_end_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            last_q     <= last_d;
        end
    end

    assign o_RAM_Address = ADDR_WIDTH'(byte_q);
    assign o_Pixel       = pixel_q;
    assign o_Pixel_Valid = valid_q;
    assign o_Line_End    = line_end_q;
    assign o_Busy        = busy_q;
    assign o_Frame_Done  = done_q;

endmodule

// File: tb/tb_frame_buffer_reader.sv
// Bench for frame_buffer_reader: two instances (RAM latency 1 and 2) on small
// frames, each backed by a sync RAM whose byte at address a is a[7:0].
module tb_frame_buffer_reader;

    localparam int unsigned AW = 15;
    localparam int unsigned FB = 8;
    localparam int unsigned LB = 4;

    logic          clk = 1'b0;
    logic          rst, start1, start2, ready;
    logic [AW-1:0] addr1, addr2;
    logic [7:0]    rd1, rd2, rd2_p;
    logic [15:0]   pix1, pix2;
    logic          v1, v2, le1, le2, busy1, busy2, done1, done2;

    int            cyc = 0;
    int            n_cmp = 0;
    int            n_err = 0;
    logic [16:0]   exp_q[$];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    always @(posedge clk) begin
        rd1   <= addr1[7:0];
        rd2_p <= addr2[7:0];
        rd2   <= rd2_p;
    end

    frame_buffer_reader #(
        .ADDR_WIDTH (AW), .FRAME_BYTES (FB), .LINE_BYTES (LB), .RAM_LATENCY (1)
    ) dut1 (
        .i_Clk (clk), .i_Reset (rst), .i_Start (start1), .o_RAM_Address (addr1),
        .i_from_RAM (rd1), .o_Pixel (pix1), .o_Pixel_Valid (v1), .i_Pixel_Ready (ready),
        .o_Line_End (le1), .o_Busy (busy1), .o_Frame_Done (done1)
    );

    frame_buffer_reader #(
        .ADDR_WIDTH (AW), .FRAME_BYTES (FB), .LINE_BYTES (LB), .RAM_LATENCY (2)
    ) dut2 (
        .i_Clk (clk), .i_Reset (rst), .i_Start (start2), .o_RAM_Address (addr2),
        .i_from_RAM (rd2), .o_Pixel (pix2), .o_Pixel_Valid (v2), .i_Pixel_Ready (ready),
        .o_Line_End (le2), .o_Busy (busy2), .o_Frame_Done (done2)
    );

    // Expected pixel stream: {line_end, high byte, low byte} per byte pair.
    function automatic void push_frame();
        int         lb;
        logic [7:0] hi, lo;
        logic       le;
        lb = int'(LB);
        for (int i = 0; i < int'(FB); i += 2) begin
            hi = 8'(i);
            lo = 8'(i + 1);
            le = ((i + 1) % lb) == (lb - 1);
            exp_q.push_back({le, hi, lo});
        end
    endfunction

    task automatic test_reset();
        int nv = 0;
        rst = 1'b1; start1 = 1'b1; start2 = 1'b1; ready = 1'b0;
        repeat (3) @(negedge clk);
        start1 = 1'b0; start2 = 1'b0;
        n_cmp++;
        if ({pix1, v1, le1, busy1, done1} !== 20'h0 || addr1 !== '0) begin
            n_err++;
            $display("FAIL reset_dut1: got pix=%h v=%0b le=%0b busy=%0b done=%0b addr=%0d want all 0", pix1, v1, le1, busy1, done1, addr1);
        end
        n_cmp++;
        if ({pix2, v2, le2, busy2, done2} !== 20'h0 || addr2 !== '0) begin
            n_err++;
            $display("FAIL reset_dut2: got pix=%h v=%0b le=%0b busy=%0b done=%0b addr=%0d want all 0", pix2, v2, le2, busy2, done2, addr2);
        end
        rst = 1'b0; ready = 1'b1;
        repeat (100) begin
            @(negedge clk);
            if (v1 || v2 || busy1 || busy2) nv++;
        end
        n_cmp++;
        if (nv != 0) begin
            n_err++;
            $display("FAIL idle_no_valid: got %0d active cycles want 0", nv);
        end
    endtask

    task automatic test_full_frame();
        logic [16:0] e;
        int          e0, d;
        int          last = 0, n = 0;
        exp_q.delete(); push_frame(); ready = 1'b1;
        @(negedge clk); start1 = 1'b1; e0 = cyc + 1;
        @(negedge clk); start1 = 1'b0;
        for (int k = 0; k < 60; k++) begin
            if (v1) begin
                e = exp_q.pop_front();
                n_cmp++;
                if ({le1, pix1} !== e) begin
                    n_err++;
                    $display("FAIL full_pixel%0d: got le=%0b pix=%h want le=%0b pix=%h", n, le1, pix1, e[16], e[15:0]);
                end
                d = cyc - ((n == 0) ? e0 : last);
                n_cmp++;
                if (d != 4) begin
                    n_err++;
                    $display("FAIL full_timing%0d: got %0d clocks want 4", n, d);
                end
                last = cyc; n++;
            end
            if (n == 4) break;
            @(negedge clk);
        end
        n_cmp++;
        if (n != 4) begin n_err++; $display("FAIL full_count: got %0d pixels want 4", n); end
        @(negedge clk);
        n_cmp++;
        if (done1 !== 1'b1 || v1 !== 1'b0) begin
            n_err++;
            $display("FAIL full_done: got done=%0b valid=%0b want done=1 valid=0", done1, v1);
        end
        @(negedge clk);
        n_cmp++;
        if (done1 !== 1'b0 || busy1 !== 1'b0 || addr1 !== '0) begin
            n_err++;
            $display("FAIL full_idle: got done=%0b busy=%0b addr=%0d want 0 0 0", done1, busy1, addr1);
        end
    endtask

    task automatic test_backpressure();
        logic [16:0] e;
        logic [15:0] hold_pix = '0;
        logic        hold = 1'b0;
        int          n = 0, stall = 0, ndone = 0;
        exp_q.delete(); push_frame(); ready = 1'b0;
        @(negedge clk); start1 = 1'b1;
        @(negedge clk); start1 = 1'b0;
        for (int k = 0; k < 200; k++) begin
            if (hold) begin
                n_cmp++;
                if (v1 !== 1'b1 || pix1 !== hold_pix) begin
                    n_err++;
                    $display("FAIL bp_hold: got valid=%0b pix=%h want valid=1 pix=%h", v1, pix1, hold_pix);
                end
            end
            if (done1) ndone++;
            if (v1 && pix1 === 16'h0203 && stall < 10) begin
                ready = 1'b0; stall++;
            end else begin
                ready = 1'($urandom_range(0, 1));
            end
            if (v1 && ready) begin
                n_cmp++;
                if (exp_q.size() == 0) begin
                    n_err++;
                    $display("FAIL bp_extra: got pix=%h want no more pixels", pix1);
                end else begin
                    e = exp_q.pop_front();
                    if ({le1, pix1} !== e) begin
                        n_err++;
                        $display("FAIL bp_pixel%0d: got le=%0b pix=%h want le=%0b pix=%h", n, le1, pix1, e[16], e[15:0]);
                    end
                end
                n++;
            end
            hold = v1 && !ready; hold_pix = pix1;
            @(negedge clk);
        end
        n_cmp++;
        if (n != 4 || ndone != 1 || stall != 10) begin
            n_err++;
            $display("FAIL bp_totals: got pixels=%0d done=%0d stall=%0d want 4 1 10", n, ndone, stall);
        end
    endtask

    task automatic test_start_busy();
        logic [16:0] e;
        int          n = 0, ndone = 0;
        exp_q.delete(); push_frame(); ready = 1'b1;
        @(negedge clk); start1 = 1'b1;
        @(negedge clk); start1 = 1'b0;
        for (int k = 0; k < 80; k++) begin
            if (done1) ndone++;
            start1 = (k == 3) || (v1 && n == 0) || done1;
            if (v1) begin
                n_cmp++;
                if (exp_q.size() == 0) begin
                    n_err++;
                    $display("FAIL sb_extra: got pix=%h want no more pixels", pix1);
                end else begin
                    e = exp_q.pop_front();
                    if ({le1, pix1} !== e) begin
                        n_err++;
                        $display("FAIL sb_pixel%0d: got le=%0b pix=%h want le=%0b pix=%h", n, le1, pix1, e[16], e[15:0]);
                    end
                end
                n++;
            end
            @(negedge clk);
        end
        start1 = 1'b0;
        n_cmp++;
        if (n != 4 || ndone != 1 || busy1 !== 1'b0) begin
            n_err++;
            $display("FAIL sb_totals: got pixels=%0d done=%0d busy=%0b want 4 1 0", n, ndone, busy1);
        end
    endtask

    task automatic test_reset_mid();
        logic [16:0] e;
        int          e0, nbad = 0, n = 0, first = -1;
        exp_q.delete(); ready = 1'b0;
        @(negedge clk); start1 = 1'b1;
        @(negedge clk); start1 = 1'b0;
        for (int k = 0; k < 40; k++) begin
            if (v1) break;
            @(negedge clk);
        end
        n_cmp++;
        if (v1 !== 1'b1 || pix1 !== 16'h0001) begin
            n_err++;
            $display("FAIL rm_present: got valid=%0b pix=%h want valid=1 pix=0001", v1, pix1);
        end
        rst = 1'b1;
        @(negedge clk); rst = 1'b0;
        n_cmp++;
        if ({pix1, v1, le1, busy1, done1} !== 20'h0 || addr1 !== '0) begin
            n_err++;
            $display("FAIL rm_outputs: got pix=%h v=%0b le=%0b busy=%0b done=%0b addr=%0d want all 0", pix1, v1, le1, busy1, done1, addr1);
        end
        ready = 1'b1;
        repeat (20) begin
            @(negedge clk);
            if (done1 || v1 || busy1) nbad++;
        end
        n_cmp++;
        if (nbad != 0) begin n_err++; $display("FAIL rm_quiet: got %0d active cycles want 0", nbad); end
        push_frame();
        @(negedge clk); start1 = 1'b1; e0 = cyc + 1;
        @(negedge clk); start1 = 1'b0;
        for (int k = 0; k < 60; k++) begin
            if (v1) begin
                if (first < 0) first = cyc - e0;
                e = exp_q.pop_front();
                n_cmp++;
                if ({le1, pix1} !== e) begin
                    n_err++;
                    $display("FAIL rm_pixel%0d: got le=%0b pix=%h want le=%0b pix=%h", n, le1, pix1, e[16], e[15:0]);
                end
                n++;
            end
            if (n == 4) break;
            @(negedge clk);
        end
        n_cmp++;
        if (n != 4 || first != 4) begin
            n_err++;
            $display("FAIL rm_restart: got pixels=%0d latency=%0d want 4 4", n, first);
        end
        repeat (3) @(negedge clk);
    endtask

    task automatic test_latency2();
        logic [16:0] e;
        int          e0, d;
        int          last = 0, n = 0;
        exp_q.delete(); push_frame(); ready = 1'b1;
        @(negedge clk); start2 = 1'b1; e0 = cyc + 1;
        @(negedge clk); start2 = 1'b0;
        for (int k = 0; k < 80; k++) begin
            if (v2) begin
                e = exp_q.pop_front();
                n_cmp++;
                if ({le2, pix2} !== e) begin
                    n_err++;
                    $display("FAIL lat2_pixel%0d: got le=%0b pix=%h want le=%0b pix=%h", n, le2, pix2, e[16], e[15:0]);
                end
                d = cyc - ((n == 0) ? e0 : last);
                n_cmp++;
                if (d != 6) begin
                    n_err++;
                    $display("FAIL lat2_timing%0d: got %0d clocks want 6", n, d);
                end
                last = cyc; n++;
            end
            if (n == 4) break;
            @(negedge clk);
        end
        n_cmp++;
        if (n != 4) begin n_err++; $display("FAIL lat2_count: got %0d pixels want 4", n); end
        @(negedge clk);
        n_cmp++;
        if (done2 !== 1'b1) begin n_err++; $display("FAIL lat2_done: got done=%0b want 1", done2); end
        @(negedge clk);
        n_cmp++;
        if (done2 !== 1'b0 || busy2 !== 1'b0) begin
            n_err++;
            $display("FAIL lat2_idle: got done=%0b busy=%0b want 0 0", done2, busy2);
        end
    endtask

    initial begin
        rst = 1'b1; start1 = 1'b0; start2 = 1'b0; ready = 1'b0;
        test_reset();
        test_full_frame();
        test_backpressure();
        test_start_busy();
        test_reset_mid();
        test_latency2();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
